// File: rtl/id_ex_stage_if.sv
// Decode -> execute bundle for id_ex_stage. It carries the decode slot, the two
// forwarding sources, stall/flush control and the EX-side outputs.
interface id_ex_stage_if #(
  parameter int DATA_W = 16
);
  // Pipeline control
  logic              stall;
  logic              flush;

  // Decode slot
  logic              idValid;
  logic [DATA_W-1:0] idPC;
  logic [DATA_W-1:0] idData1;
  logic [DATA_W-1:0] idData2;
  logic [DATA_W-1:0] idImm;
  logic [2:0]        idRs1;
  logic [2:0]        idRs2;
  logic [1:0]        idReadSpecReg;
  logic              idUse1;
  logic              idUse2;
  logic [2:0]        idRd;
  logic [1:0]        idWriteSpecReg;
  logic              idRegWrite;
  logic              idMemRead;
  logic              idMemWrite;
  logic [3:0]        idAluOp;

  // Forward source A: result leaving EX (newest)
  logic              fwdARegWrite;
  logic [2:0]        fwdARd;
  logic [1:0]        fwdASpec;
  logic [DATA_W-1:0] fwdAData;

  // Forward source B: result leaving MEM (older)
  logic              fwdBRegWrite;
  logic [2:0]        fwdBRd;
  logic [1:0]        fwdBSpec;
  logic [DATA_W-1:0] fwdBData;

  // EX-side outputs
  logic              exValid;
  logic [DATA_W-1:0] exPC;
  logic [DATA_W-1:0] exData1;
  logic [DATA_W-1:0] exData2;
  logic [DATA_W-1:0] exImm;
  logic [2:0]        exRd;
  logic [1:0]        exWriteSpecReg;
  logic              exRegWrite;
  logic              exMemRead;
  logic              exMemWrite;
  logic [3:0]        exAluOp;
  logic              hazardStall;
  logic [15:0]       bubbleCount;

  // Pipeline side: drives decode/forward/control, observes EX outputs.
  modport master (
    output stall, flush,
    output idValid, idPC, idData1, idData2, idImm, idRs1, idRs2, idReadSpecReg,
    output idUse1, idUse2, idRd, idWriteSpecReg, idRegWrite, idMemRead,
    output idMemWrite, idAluOp,
    output fwdARegWrite, fwdARd, fwdASpec, fwdAData,
    output fwdBRegWrite, fwdBRd, fwdBSpec, fwdBData,
    input  exValid, exPC, exData1, exData2, exImm, exRd, exWriteSpecReg,
    input  exRegWrite, exMemRead, exMemWrite, exAluOp, hazardStall, bubbleCount
  );

  // The ID/EX register itself.
  modport slave (
    input  stall, flush,
    input  idValid, idPC, idData1, idData2, idImm, idRs1, idRs2, idReadSpecReg,
    input  idUse1, idUse2, idRd, idWriteSpecReg, idRegWrite, idMemRead,
    input  idMemWrite, idAluOp,
    input  fwdARegWrite, fwdARd, fwdASpec, fwdAData,
    input  fwdBRegWrite, fwdBRd, fwdBSpec, fwdBData,
    output exValid, exPC, exData1, exData2, exImm, exRd, exWriteSpecReg,
    output exRegWrite, exMemRead, exMemWrite, exAluOp, hazardStall, bubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit CPU. Captures the decode slot with
// operand forwarding, inserts a bubble on load-use hazards, and honours
// downstream stall and branch flush (flush always wins).
module id_ex_stage #(
  parameter int DATA_W = 16,
  // Width of the internal bubble counter (1..16). The port is always 16 bits,
  // zero-extended; the counter saturates at its own all-ones value.
  parameter int BCNT_W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  id_ex_stage_if.slave bus
);

  // Register key {spec, index}; spec = 00 names a general register, any other
  // spec value names a special register and the index is ignored.
  typedef logic [4:0] reg_key_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] imm;
    logic [2:0]        rd;
    logic [1:0]        wspec;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        alu_op;
  } ex_slot_t;

  function automatic logic keys_match(input reg_key_t a, input reg_key_t b);
    return (a[4:3] == b[4:3]) && ((a[4:3] != 2'b00) || (a[2:0] == b[2:0]));
  endfunction

  ex_slot_t          r_ex;
  logic [BCNT_W-1:0] r_bubble_count;

  reg_key_t          w_key1;
  reg_key_t          w_key2;
  reg_key_t          w_fwda_key;
  reg_key_t          w_fwdb_key;
  reg_key_t          w_ex_key;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  ex_slot_t          w_capture;
  logic              w_ex_is_load;
  logic              w_use_hit;
  logic              w_hazard;
  logic              w_bcnt_full;

  // Operand 2 never reads a special register, so its key is always general.
  assign w_key1     = {bus.idReadSpecReg, bus.idRs1};
  assign w_key2     = {2'b00, bus.idRs2};
  assign w_fwda_key = {bus.fwdASpec, bus.fwdARd};
  assign w_fwdb_key = {bus.fwdBSpec, bus.fwdBRd};
  assign w_ex_key   = {r_ex.wspec, r_ex.rd};

  // Operand forwarding: A (leaving EX) is newer than B (leaving MEM) and wins.
  always_comb begin
    // NOTE: every output gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    w_op1 = bus.idData1;
    w_op2 = bus.idData2;
    if (bus.fwdARegWrite && keys_match(w_fwda_key, w_key1)) begin
      w_op1 = bus.fwdAData;
    end else if (bus.fwdBRegWrite && keys_match(w_fwdb_key, w_key1)) begin
      w_op1 = bus.fwdBData;
    end
    if (bus.fwdARegWrite && keys_match(w_fwda_key, w_key2)) begin
      w_op2 = bus.fwdAData;
    end else if (bus.fwdBRegWrite && keys_match(w_fwdb_key, w_key2)) begin
      w_op2 = bus.fwdBData;
    end
  end

  // Decode slot as it would enter EX; exValid simply follows idValid.
  always_comb begin
    w_capture           = '0;
    w_capture.valid     = bus.idValid;
    w_capture.pc        = bus.idPC;
    w_capture.data1     = w_op1;
    w_capture.data2     = w_op2;
    w_capture.imm       = bus.idImm;
    w_capture.rd        = bus.idRd;
    w_capture.wspec     = bus.idWriteSpecReg;
    w_capture.reg_write = bus.idRegWrite;
    w_capture.mem_read  = bus.idMemRead;
    w_capture.mem_write = bus.idMemWrite;
    w_capture.alu_op    = bus.idAluOp;
  end

  // Load-use: a load in EX whose destination is consumed by the decode slot.
  // A downstream stall already freezes everything, so the hazard is masked.
  assign w_ex_is_load = r_ex.valid & r_ex.mem_read & r_ex.reg_write;
  assign w_use_hit    = (bus.idUse1 & keys_match(w_key1, w_ex_key))
                      | (bus.idUse2 & keys_match(w_key2, w_ex_key));
  assign w_hazard     = ~bus.stall & w_ex_is_load & bus.idValid & w_use_hit;
  assign w_bcnt_full  = &r_bubble_count;

  // Slot register, priority: reset > flush > stall > load-use bubble > capture.
  // A bubble is an all-zero slot so data fields never carry stale values.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (RST) begin
      r_ex <= '0;
    end else if (bus.flush) begin
      r_ex <= '0;
    end else if (bus.stall) begin
      r_ex <= r_ex;
    end else if (w_hazard) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_capture;
    end
  end

  // Saturating count of load-use bubbles; a flush in the same cycle takes the
  // slot and is not counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bubble_count <= '0;
    end else if (!bus.flush && w_hazard && !w_bcnt_full) begin
      r_bubble_count <= r_bubble_count + BCNT_W'(1);
    end
  end

  assign bus.exValid        = r_ex.valid;
  assign bus.exPC           = r_ex.pc;
  assign bus.exData1        = r_ex.data1;
  assign bus.exData2        = r_ex.data2;
  assign bus.exImm          = r_ex.imm;
  assign bus.exRd           = r_ex.rd;
  assign bus.exWriteSpecReg = r_ex.wspec;
  assign bus.exRegWrite     = r_ex.reg_write;
  assign bus.exMemRead      = r_ex.mem_read;
  assign bus.exMemWrite     = r_ex.mem_write;
  assign bus.exAluOp        = r_ex.alu_op;
  assign bus.hazardStall    = w_hazard;
  assign bus.bubbleCount    = 16'(r_bubble_count);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed forwarding table, hand-written
// load-use / stall / flush sequences, counter saturation and random traffic,
// all compared against a register-key level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        stall, flush, valid;
    logic [15:0] pc, d1, d2, imm;
    logic [2:0]  rs1, rs2;
    logic [1:0]  rspec;
    logic        use1, use2;
    logic [2:0]  rd;
    logic [1:0]  wspec;
    logic        rw, mr, mw;
    logic [3:0]  alu;
    logic        fa_rw;
    logic [2:0]  fa_rd;
    logic [1:0]  fa_spec;
    logic [15:0] fa_data;
    logic        fb_rw;
    logic [2:0]  fb_rd;
    logic [1:0]  fb_spec;
    logic [15:0] fb_data;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        ev;
    logic [15:0] ed1, ed2;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [15:0] pc, d1, d2, imm;
    logic [2:0]  rd;
    logic [1:0]  ws;
    logic        rw, mr, mw;
    logic [3:0]  alu;
    int          bubbles;
  } model_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_vec = 0;
  int     n_err = 0;
  model_t m;

  id_ex_stage_if #(.DATA_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(16)) bus_s ();

  id_ex_stage #(.DATA_W(16)) dut (.CLK(clk), .RST(rst), .bus(bus));
  // Narrow-counter instance sharing the same traffic, used to reach saturation
  // within a short run.
  id_ex_stage #(.DATA_W(16), .BCNT_W(4)) dut_s (.CLK(clk), .RST(rst), .bus(bus_s));

  assign bus_s.stall          = bus.stall;
  assign bus_s.flush          = bus.flush;
  assign bus_s.idValid        = bus.idValid;
  assign bus_s.idPC           = bus.idPC;
  assign bus_s.idData1        = bus.idData1;
  assign bus_s.idData2        = bus.idData2;
  assign bus_s.idImm          = bus.idImm;
  assign bus_s.idRs1          = bus.idRs1;
  assign bus_s.idRs2          = bus.idRs2;
  assign bus_s.idReadSpecReg  = bus.idReadSpecReg;
  assign bus_s.idUse1         = bus.idUse1;
  assign bus_s.idUse2         = bus.idUse2;
  assign bus_s.idRd           = bus.idRd;
  assign bus_s.idWriteSpecReg = bus.idWriteSpecReg;
  assign bus_s.idRegWrite     = bus.idRegWrite;
  assign bus_s.idMemRead      = bus.idMemRead;
  assign bus_s.idMemWrite     = bus.idMemWrite;
  assign bus_s.idAluOp        = bus.idAluOp;
  assign bus_s.fwdARegWrite   = bus.fwdARegWrite;
  assign bus_s.fwdARd         = bus.fwdARd;
  assign bus_s.fwdASpec       = bus.fwdASpec;
  assign bus_s.fwdAData       = bus.fwdAData;
  assign bus_s.fwdBRegWrite   = bus.fwdBRegWrite;
  assign bus_s.fwdBRd         = bus.fwdBRd;
  assign bus_s.fwdBSpec       = bus.fwdBSpec;
  assign bus_s.fwdBData       = bus.fwdBData;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit same_reg(input logic [1:0] sa, input logic [2:0] ia,
                                  input logic [1:0] sb, input logic [2:0] ib);
    if (sa != sb) return 1'b0;
    if (sa != 2'b00) return 1'b1;
    return ia == ib;
  endfunction

  function automatic logic [15:0] operand(input logic [1:0] spec, input logic [2:0] idx,
                                          input logic [15:0] rf_val, input stim_t s);
    if (s.fa_rw && same_reg(s.fa_spec, s.fa_rd, spec, idx)) return s.fa_data;
    if (s.fb_rw && same_reg(s.fb_spec, s.fb_rd, spec, idx)) return s.fb_data;
    return rf_val;
  endfunction

  function automatic bit model_hazard(input stim_t s);
    bit reads_load;
    if (s.stall) return 1'b0;
    reads_load = (s.use1 && same_reg(s.rspec, s.rs1, m.ws, m.rd))
              || (s.use2 && same_reg(2'b00, s.rs2, m.ws, m.rd));
    return m.valid && m.mr && m.rw && s.valid && reads_load;
  endfunction

  task automatic clear_slot();
    int b;
    b = m.bubbles;
    m = '{default: 0};
    m.bubbles = b;
  endtask

  task automatic model_step(input stim_t s, input logic r);
    bit hz;
    hz = model_hazard(s);
    if (r) begin
      m = '{default: 0};
    end else if (s.flush) begin
      clear_slot();
    end else if (s.stall) begin
    end else if (hz) begin
      clear_slot();
      if (m.bubbles < 65535) m.bubbles++;
    end else begin
      m.valid = s.valid;
      m.pc    = s.pc;
      m.d1    = operand(s.rspec, s.rs1, s.d1, s);
      m.d2    = operand(2'b00, s.rs2, s.d2, s);
      m.imm   = s.imm;
      m.rd    = s.rd;
      m.ws    = s.wspec;
      m.rw    = s.rw;
      m.mr    = s.mr;
      m.mw    = s.mw;
      m.alu   = s.alu;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input stim_t s);
    bus.stall = s.stall;           bus.flush = s.flush;
    bus.idValid = s.valid;         bus.idPC = s.pc;
    bus.idData1 = s.d1;            bus.idData2 = s.d2;
    bus.idImm = s.imm;             bus.idRs1 = s.rs1;
    bus.idRs2 = s.rs2;             bus.idReadSpecReg = s.rspec;
    bus.idUse1 = s.use1;           bus.idUse2 = s.use2;
    bus.idRd = s.rd;               bus.idWriteSpecReg = s.wspec;
    bus.idRegWrite = s.rw;         bus.idMemRead = s.mr;
    bus.idMemWrite = s.mw;         bus.idAluOp = s.alu;
    bus.fwdARegWrite = s.fa_rw;    bus.fwdARd = s.fa_rd;
    bus.fwdASpec = s.fa_spec;      bus.fwdAData = s.fa_data;
    bus.fwdBRegWrite = s.fb_rw;    bus.fwdBRd = s.fb_rd;
    bus.fwdBSpec = s.fb_spec;      bus.fwdBData = s.fb_data;
  endtask

  function automatic stim_t with_fa(input stim_t s, input logic [1:0] spec,
                                    input logic [2:0] rd, input logic [15:0] data);
    s.fa_rw = 1'b1; s.fa_spec = spec; s.fa_rd = rd; s.fa_data = data;
    return s;
  endfunction

  function automatic stim_t with_fb(input stim_t s, input logic [1:0] spec,
                                    input logic [2:0] rd, input logic [15:0] data);
    s.fb_rw = 1'b1; s.fb_spec = spec; s.fb_rd = rd; s.fb_data = data;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.stall   = ($urandom_range(7) == 0);
    s.flush   = ($urandom_range(9) == 0);
    s.valid   = ($urandom_range(3) != 0);
    s.pc      = 16'($urandom);
    s.d1      = 16'($urandom);
    s.d2      = 16'($urandom);
    s.imm     = 16'($urandom);
    s.rs1     = 3'($urandom_range(3));
    s.rs2     = 3'($urandom_range(3));
    s.rspec   = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
    s.use1    = 1'($urandom);
    s.use2    = 1'($urandom);
    s.rd      = 3'($urandom_range(3));
    s.wspec   = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
    s.rw      = 1'($urandom);
    s.mr      = 1'($urandom);
    s.mw      = 1'($urandom);
    s.alu     = 4'($urandom);
    s.fa_rw   = 1'($urandom);
    s.fa_rd   = 3'($urandom_range(3));
    s.fa_spec = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
    s.fa_data = 16'($urandom);
    s.fb_rw   = 1'($urandom);
    s.fb_rd   = 3'($urandom_range(3));
    s.fb_spec = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
    s.fb_data = 16'($urandom);
    return s;
  endfunction

  task automatic check_outputs();
    int sat_exp;
    sat_exp = (m.bubbles > 15) ? 15 : m.bubbles;
    check("exValid",        32'(bus.exValid),        32'(m.valid));
    check("exPC",           32'(bus.exPC),           32'(m.pc));
    check("exData1",        32'(bus.exData1),        32'(m.d1));
    check("exData2",        32'(bus.exData2),        32'(m.d2));
    check("exImm",          32'(bus.exImm),          32'(m.imm));
    check("exRd",           32'(bus.exRd),           32'(m.rd));
    check("exWriteSpecReg", 32'(bus.exWriteSpecReg), 32'(m.ws));
    check("exRegWrite",     32'(bus.exRegWrite),     32'(m.rw));
    check("exMemRead",      32'(bus.exMemRead),      32'(m.mr));
    check("exMemWrite",     32'(bus.exMemWrite),     32'(m.mw));
    check("exAluOp",        32'(bus.exAluOp),        32'(m.alu));
    check("bubbleCount",    32'(bus.bubbleCount),    32'(m.bubbles));
    check("bubbleCount_w4", 32'(bus_s.bubbleCount),  32'(sat_exp));
  endtask

  // One clock: drive at negedge, sample hazard mid-cycle, check state after edge.
  task automatic cycle(input stim_t s, input logic r, output logic haz);
    @(negedge clk);
    rst = r;
    drive(s);
    #1;
    haz = bus.hazardStall;
    check("hazardStall", 32'(haz), 32'(model_hazard(s)));
    @(posedge clk);
    model_step(s, r);
    #1;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    vec_t  tbl [10];
    stim_t idle, b, t, ld, dep, k, s;
    logic  haz;

    m    = '{default: 0};
    idle = '0;

    b       = '0;
    b.valid = 1'b1; b.pc = 16'h0100; b.use1 = 1'b1; b.use2 = 1'b1;
    b.d1    = 16'h0003; b.d2 = 16'h0004; b.rs1 = 3'd2; b.rs2 = 3'd3;
    b.rd    = 3'd5; b.rw = 1'b1; b.alu = 4'h1;

    tbl[0].s = with_fb(with_fa(b, 2'b00, 3'd2, 16'h00AA), 2'b00, 3'd2, 16'h0055);
    tbl[0].ev = 1'b1; tbl[0].ed1 = 16'h00AA; tbl[0].ed2 = 16'h0004;
    tbl[1].s = with_fb(b, 2'b00, 3'd2, 16'h0055);
    tbl[1].ev = 1'b1; tbl[1].ed1 = 16'h0055; tbl[1].ed2 = 16'h0004;
    tbl[2].s = with_fa(b, 2'b00, 3'd3, 16'h0033);
    tbl[2].ev = 1'b1; tbl[2].ed1 = 16'h0003; tbl[2].ed2 = 16'h0033;
    t = b; t.rspec = 2'b01;
    tbl[3].s = with_fa(t, 2'b01, 3'd6, 16'hBF00);
    tbl[3].ev = 1'b1; tbl[3].ed1 = 16'hBF00; tbl[3].ed2 = 16'h0004;
    t = b; t.rspec = 2'b01; t.rs1 = 3'd1;
    tbl[4].s = with_fa(t, 2'b00, 3'd1, 16'h1111);
    tbl[4].ev = 1'b1; tbl[4].ed1 = 16'h0003; tbl[4].ed2 = 16'h0004;
    t = b; t.rs2 = 3'd0;
    tbl[5].s = with_fb(t, 2'b00, 3'd0, 16'h0077);
    tbl[5].ev = 1'b1; tbl[5].ed1 = 16'h0003; tbl[5].ed2 = 16'h0077;
    tbl[6].s = with_fa(b, 2'b01, 3'd3, 16'h9999);
    tbl[6].ev = 1'b1; tbl[6].ed1 = 16'h0003; tbl[6].ed2 = 16'h0004;
    t = b; t.rspec = 2'b10;
    tbl[7].s = with_fb(with_fa(t, 2'b11, 3'd2, 16'h7777), 2'b10, 3'd0, 16'h8888);
    tbl[7].ev = 1'b1; tbl[7].ed1 = 16'h8888; tbl[7].ed2 = 16'h0004;
    t = b; t.valid = 1'b0;
    tbl[8].s = t;
    tbl[8].ev = 1'b0; tbl[8].ed1 = 16'h0003; tbl[8].ed2 = 16'h0004;
    tbl[9].s = with_fb(with_fa(b, 2'b00, 3'd2, 16'h00AA), 2'b00, 3'd3, 16'h0055);
    tbl[9].ev = 1'b1; tbl[9].ed1 = 16'h00AA; tbl[9].ed2 = 16'h0055;

    drive(idle);

    // Reset for one cycle, then idle.
    cycle(idle, 1'b1, haz);
    cycle(idle, 1'b0, haz);
    check("rst_exValid",     32'(bus.exValid),     32'd0);
    check("rst_exData1",     32'(bus.exData1),     32'd0);
    check("rst_bubbleCount", 32'(bus.bubbleCount), 32'd0);
    check("rst_hazardStall", 32'(haz),             32'd0);

    // Forwarding table.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].s, 1'b0, haz);
      check("tbl_exValid", 32'(bus.exValid), 32'(tbl[i].ev));
      check("tbl_exData1", 32'(bus.exData1), 32'(tbl[i].ed1));
      check("tbl_exData2", 32'(bus.exData2), 32'(tbl[i].ed2));
    end

    // Load-use: LW R4 in EX, consumer reads R4 on operand 2.
    ld = '0; ld.valid = 1'b1; ld.pc = 16'h0200; ld.rd = 3'd4; ld.rw = 1'b1;
    ld.mr = 1'b1; ld.alu = 4'h2; ld.imm = 16'h0008;
    dep = '0; dep.valid = 1'b1; dep.pc = 16'h0202; dep.rs1 = 3'd1; dep.use1 = 1'b1;
    dep.d1 = 16'h0001; dep.rs2 = 3'd4; dep.use2 = 1'b1; dep.d2 = 16'hDEAD;
    dep.rd = 3'd5; dep.rw = 1'b1; dep.alu = 4'h1;
    cycle(ld, 1'b0, haz);
    cycle(dep, 1'b0, haz);
    check("lu_hazardStall", 32'(haz),             32'd1);
    check("lu_bubble",      32'(bus.exValid),     32'd0);
    check("lu_count",       32'(bus.bubbleCount), 32'd1);
    cycle(with_fb(dep, 2'b00, 3'd4, 16'h1234), 1'b0, haz);
    check("lu_retry_haz",   32'(haz),             32'd0);
    check("lu_retry_valid", 32'(bus.exValid),     32'd1);
    check("lu_fwd_data2",   32'(bus.exData2),     32'h1234);

    // Stall for three cycles with changing inputs: outputs frozen.
    k = '0; k.valid = 1'b1; k.pc = 16'h0300; k.d1 = 16'h1357; k.d2 = 16'h2468;
    k.imm = 16'h00FF; k.rs1 = 3'd5; k.rs2 = 3'd6; k.rd = 3'd2; k.rw = 1'b1; k.alu = 4'h3;
    cycle(k, 1'b0, haz);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.stall = 1'b1; s.flush = 1'b0;
      cycle(s, 1'b0, haz);
      check("stall_exPC",    32'(bus.exPC),    32'h0300);
      check("stall_exData1", 32'(bus.exData1), 32'h1357);
      check("stall_exImm",   32'(bus.exImm),   32'h00FF);
      check("stall_exValid", 32'(bus.exValid), 32'd1);
    end
    s = rand_stim(); s.stall = 1'b1; s.flush = 1'b1;
    cycle(s, 1'b0, haz);
    check("stall_flush_valid", 32'(bus.exValid),    32'd0);
    check("stall_flush_rw",    32'(bus.exRegWrite), 32'd0);

    // Stall masks the hazard even with a dependent load in EX.
    cycle(ld, 1'b0, haz);
    s = dep; s.stall = 1'b1;
    cycle(s, 1'b0, haz);
    check("stall_masks_haz",  32'(haz),             32'd0);
    check("stall_keeps_load", 32'(bus.exMemRead),   32'd1);
    check("stall_no_count",   32'(bus.bubbleCount), 32'd1);

    // Flush and hazard together: one bubble, not counted.
    s = dep; s.flush = 1'b1;
    cycle(s, 1'b0, haz);
    check("flush_haz_seen",  32'(haz),             32'd1);
    check("flush_haz_valid", 32'(bus.exValid),     32'd0);
    check("flush_haz_count", 32'(bus.bubbleCount), 32'd1);

    // Repeated load-use bubbles; the 4-bit counter instance saturates at 15.
    cycle(idle, 1'b1, haz);
    for (int i = 0; i < 20; i++) begin
      cycle(ld, 1'b0, haz);
      cycle(dep, 1'b0, haz);
      if (i == 9) check("sat_mid", 32'(bus_s.bubbleCount), 32'd10);
    end
    check("sat_hold_w4",  32'(bus_s.bubbleCount), 32'h000F);
    check("sat_count16",  32'(bus.bubbleCount),   32'd20);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(rand_stim(), ($urandom_range(199) == 0), haz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
